// File: rtl/async_cache_3port.sv
// ---------------------------------------------------------------------------
// async_cache_3port
//   Data cache for the asynchronous processor: a 2^ADDRESS_SIZE x N memory
//   with three write ports and three registered read ports, fronted by a
//   four-phase req/ack handshake. Each handshake commits all enabled writes
//   and captures all enabled reads on a single clock edge.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   write_data_1..3            write data per port
//   wac_1..3 / rac_1..3        write / read addresses per port
//   write_enable_1..3          per-port write enable
//   read_enable_1..3           per-port read enable
//   out_data_1..3              registered read data (held when not read)
//   req                        four-phase request, asynchronous to clk
//   ack                        four-phase acknowledge
//   trig                       one-cycle pulse on transaction commit
// ---------------------------------------------------------------------------
module async_cache_3port #(
    parameter int N            = 32,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            write_data_1,
    input  logic [N-1:0]            write_data_2,
    input  logic [N-1:0]            write_data_3,
    input  logic [ADDRESS_SIZE-1:0] wac_1,
    input  logic [ADDRESS_SIZE-1:0] wac_2,
    input  logic [ADDRESS_SIZE-1:0] wac_3,
    input  logic [ADDRESS_SIZE-1:0] rac_1,
    input  logic [ADDRESS_SIZE-1:0] rac_2,
    input  logic [ADDRESS_SIZE-1:0] rac_3,
    input  logic                    write_enable_1,
    input  logic                    write_enable_2,
    input  logic                    write_enable_3,
    input  logic                    read_enable_1,
    input  logic                    read_enable_2,
    input  logic                    read_enable_3,
    output logic [N-1:0]            out_data_1,
    output logic [N-1:0]            out_data_2,
    output logic [N-1:0]            out_data_3,
    input  logic                    req,
    output logic                    ack,
    output logic                    trig
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;

    // ST_ACK is exactly "ack is high": waiting for the requester to drop req.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   req_meta_q, req_s_q;
    logic   trig_q, trig_d;
    logic   commit;

    logic [N-1:0] out_data_q [3];
    logic [N-1:0] out_data_d [3];
    logic [N-1:0] mem [DEPTH];

    // Port bundling so the datapath can be written once per port index.
    logic [ADDRESS_SIZE-1:0] wac [3];
    logic [ADDRESS_SIZE-1:0] rac [3];
    logic [N-1:0]            wdata [3];
    logic [2:0]              we, re;

    assign wac[0] = wac_1;
    assign wac[1] = wac_2;
    assign wac[2] = wac_3;
    assign rac[0] = rac_1;
    assign rac[1] = rac_2;
    assign rac[2] = rac_3;
    assign wdata[0] = write_data_1;
    assign wdata[1] = write_data_2;
    assign wdata[2] = write_data_3;
    assign we = {write_enable_3, write_enable_2, write_enable_1};
    assign re = {read_enable_3, read_enable_2, read_enable_1};

    // Two-flop synchronizer for the asynchronous request.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
        end else begin
            req_meta_q <= req;
            req_s_q    <= req_meta_q;
        end
    end

    // Handshake FSM and read capture. Reads see the memory contents before
    // this edge's writes land, giving read-before-write within a transaction.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d    = state_q;
        trig_d     = 1'b0;
        commit     = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s_q) begin
                    commit  = 1'b1;
                    trig_d  = 1'b1;
                    state_d = ST_ACK;
                    for (int i = 0; i < 3; i++) begin
                        if (re[i]) out_data_d[i] = mem[rac[i]];
                    end
                end
            end
            ST_ACK: begin
                // A held req does nothing; only its release re-arms a commit.
                if (!req_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
            for (int i = 0; i < 3; i++) out_data_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            out_data_q <= out_data_d;
        end
    end

    // NOTE: the memory array has no reset; it maps to RAM and its contents
    // are undefined until written. Later assignments win, so on a shared
    // address port 3 beats port 2 beats port 1.
    always_ff @(posedge clk) begin
        if (commit && we[0]) mem[wac[0]] <= wdata[0];
        if (commit && we[1]) mem[wac[1]] <= wdata[1];
        if (commit && we[2]) mem[wac[2]] <= wdata[2];
    end

    assign out_data_1 = out_data_q[0];
    assign out_data_2 = out_data_q[1];
    assign out_data_3 = out_data_q[2];
    assign ack        = (state_q == ST_ACK);
    assign trig       = trig_q;

endmodule

// File: tb/tb_async_cache_3port.sv
// ---------------------------------------------------------------------------
// tb_async_cache_3port
//   Directed bench for async_cache_3port. A table of transactions (enables,
//   addresses, data, expected read outputs, req hold time) is driven through
//   a full four-phase handshake each; hand-written sequences cover reset
//   mid-handshake and a transaction aborted by reset before its commit edge.
// ---------------------------------------------------------------------------
module tb_async_cache_3port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] write_data_1, write_data_2, write_data_3;
    logic [11:0] wac_1, wac_2, wac_3, rac_1, rac_2, rac_3;
    logic        write_enable_1, write_enable_2, write_enable_3;
    logic        read_enable_1, read_enable_2, read_enable_3;
    logic [31:0] out_data_1, out_data_2, out_data_3;
    logic        req = 1'b0;
    logic        ack, trig;

    int n_checks = 0;
    int n_errors = 0;

    async_cache_3port #(.N(32), .ADDRESS_SIZE(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .write_data_1(write_data_1), .write_data_2(write_data_2), .write_data_3(write_data_3),
        .wac_1(wac_1), .wac_2(wac_2), .wac_3(wac_3),
        .rac_1(rac_1), .rac_2(rac_2), .rac_3(rac_3),
        .write_enable_1(write_enable_1), .write_enable_2(write_enable_2),
        .write_enable_3(write_enable_3),
        .read_enable_1(read_enable_1), .read_enable_2(read_enable_2),
        .read_enable_3(read_enable_3),
        .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
        .req(req), .ack(ack), .trig(trig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        we;    // bit 0 = port 1
        logic [2:0]        re;
        logic [2:0][11:0]  wa;
        logic [2:0][11:0]  ra;
        logic [2:0][31:0]  wd;
        logic [2:0][31:0]  exp;   // expected out_data after the commit
        int                hold;  // extra cycles req stays high after ack
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [2:0] we, input logic [2:0] re,
        input logic [11:0] wa1, input logic [11:0] wa2, input logic [11:0] wa3,
        input logic [11:0] ra1, input logic [11:0] ra2, input logic [11:0] ra3,
        input logic [31:0] wd1, input logic [31:0] wd2, input logic [31:0] wd3,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
        input int hold);
        vec_t v;
        v.we = we;
        v.re = re;
        v.wa = {wa3, wa2, wa1};
        v.ra = {ra3, ra2, ra1};
        v.wd = {wd3, wd2, wd1};
        v.exp = {e3, e2, e1};
        v.hold = hold;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        {write_enable_3, write_enable_2, write_enable_1} = v.we;
        {read_enable_3, read_enable_2, read_enable_1}    = v.re;
        wac_1 = v.wa[0]; wac_2 = v.wa[1]; wac_3 = v.wa[2];
        rac_1 = v.ra[0]; rac_2 = v.ra[1]; rac_3 = v.ra[2];
        write_data_1 = v.wd[0]; write_data_2 = v.wd[1]; write_data_3 = v.wd[2];
    endtask

    // Full handshake: inputs and req change on the falling edge; outputs are
    // sampled 1 time unit after each rising edge.
    task automatic run_txn(input vec_t v, input int idx);
        int edges;
        int extra_trig;
        string tag;
        tag = $sformatf("txn%0d", idx);
        @(negedge clk);
        drive(v);
        req = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!ack && edges < 20);
        check({tag, " ack_rise_edges"}, 32'(edges), 32'd3);
        check({tag, " trig_on"}, 32'(trig), 32'd1);
        @(posedge clk); #1;
        check({tag, " trig_off"}, 32'(trig), 32'd0);
        extra_trig = 0;
        for (int c = 0; c < v.hold; c++) begin
            @(posedge clk); #1;
            if (trig) extra_trig++;
        end
        check({tag, " extra_trig"}, 32'(extra_trig), 32'd0);
        check({tag, " ack_held"}, 32'(ack), 32'd1);
        check({tag, " out_data_1"}, out_data_1, v.exp[0]);
        check({tag, " out_data_2"}, out_data_2, v.exp[1]);
        check({tag, " out_data_3"}, out_data_3, v.exp[2]);
        @(negedge clk);
        req = 1'b0;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (ack && edges < 20);
        check({tag, " ack_fall_edges"}, 32'(edges), 32'd3);
    endtask

    initial begin
        vec_t v;
        int   edges;
        logic [2:0] z3;
        logic [11:0] z12;
        logic [31:0] z32;
        z3 = 3'b000; z12 = 12'h000; z32 = 32'h0;

        // Transaction table: {we, re, wa1..3, ra1..3, wd1..3, exp1..3, hold}
        // 0: single write port 1
        vecs.push_back(mk(3'b001, z3, 12'h005, z12, z12, z12, z12, z12,
                          32'hDEADBEEF, z32, z32, z32, z32, z32, 0));
        // 1: read it back on port 2
        vecs.push_back(mk(z3, 3'b010, z12, z12, z12, z12, 12'h005, z12,
                          z32, z32, z32, z32, 32'hDEADBEEF, z32, 0));
        // 2: three parallel writes spanning the address range
        vecs.push_back(mk(3'b111, z3, 12'h000, 12'h7FF, 12'hFFF, z12, z12, z12,
                          32'h11111111, 32'h22222222, 32'h33333333,
                          z32, 32'hDEADBEEF, z32, 0));
        // 3: read the three back in parallel
        vecs.push_back(mk(z3, 3'b111, z12, z12, z12, 12'h000, 12'h7FF, 12'hFFF,
                          z32, z32, z32,
                          32'h11111111, 32'h22222222, 32'h33333333, 0));
        // 4: preload 0x010 from port 2
        vecs.push_back(mk(3'b010, z3, z12, 12'h010, z12, z12, z12, z12,
                          z32, 32'hAAAAAAAA, z32,
                          32'h11111111, 32'h22222222, 32'h33333333, 0));
        // 5: ports 1 and 3 write 0x010 while port 1 reads it (old value)
        vecs.push_back(mk(3'b101, 3'b001, 12'h010, z12, 12'h010, 12'h010, z12, z12,
                          32'h00000001, z32, 32'h00000003,
                          32'hAAAAAAAA, 32'h22222222, 32'h33333333, 0));
        // 6: port 3 must have won the conflict
        vecs.push_back(mk(z3, 3'b010, z12, z12, z12, z12, 12'h010, z12,
                          z32, z32, z32,
                          32'hAAAAAAAA, 32'h00000003, 32'h33333333, 0));
        // 7: port 2 disabled (address points at different data) holds its value
        vecs.push_back(mk(z3, 3'b101, z12, z12, z12, 12'h005, 12'h7FF, 12'h000,
                          z32, z32, z32,
                          32'hDEADBEEF, 32'h00000003, 32'h11111111, 0));
        // 8: all enables low: handshake completes, nothing changes
        vecs.push_back(mk(z3, z3, 12'h005, 12'h005, 12'h005, 12'h000, 12'h000, 12'h000,
                          32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'hDEADBEEF, 32'h00000003, 32'h11111111, 0));
        // 9: held req for 10 cycles; a second commit would make out_data_2 new
        vecs.push_back(mk(3'b001, 3'b010, 12'h005, z12, z12, z12, 12'h005, z12,
                          32'h12345678, z32, z32,
                          32'hDEADBEEF, 32'hDEADBEEF, 32'h11111111, 10));
        // 10: the held transaction's write landed exactly once
        vecs.push_back(mk(z3, 3'b001, z12, z12, z12, 12'h005, z12, z12,
                          z32, z32, z32,
                          32'h12345678, 32'hDEADBEEF, 32'h11111111, 0));

        drive(mk(z3, z3, z12, z12, z12, z12, z12, z12, z32, z32, z32, z32, z32, z32, 0));

        // Reset state
        #12;
        check("reset ack", 32'(ack), 32'd0);
        check("reset trig", 32'(trig), 32'd0);
        check("reset out_data_1", out_data_1, 32'h0);
        check("reset out_data_2", out_data_2, 32'h0);
        check("reset out_data_3", out_data_3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i], i);

        // Reset before the commit edge: handshake aborted, memory untouched.
        @(negedge clk);
        drive(mk(3'b001, z3, 12'h000, z12, z12, z12, z12, z12,
                 32'hBAD0BAD0, z32, z32, z32, z32, z32, 0));
        req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("abort ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Outputs were cleared by the reset; 0x000 keeps its old data.
        run_txn(mk(z3, 3'b100, z12, z12, z12, z12, z12, 12'h000,
                   z32, z32, z32, z32, z32, 32'h11111111, 0), 100);

        // Reset mid-handshake, right after the commit edge, between clock edges.
        @(negedge clk);
        drive(mk(z3, 3'b111, z12, z12, z12, 12'h000, 12'h7FF, 12'hFFF,
                 z32, z32, z32, z32, z32, z32, 0));
        req = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!ack && edges < 20);
        check("midrst ack_before", 32'(ack), 32'd1);
        check("midrst out_data_2_before", out_data_2, 32'h22222222);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst ack", 32'(ack), 32'd0);
        check("midrst trig", 32'(trig), 32'd0);
        check("midrst out_data_1", out_data_1, 32'h0);
        check("midrst out_data_2", out_data_2, 32'h0);
        check("midrst out_data_3", out_data_3, 32'h0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_cache_3port.md
Name: async_cache_3port

Overview:
- Three-write-port, three-read-port 32-bit data cache with a four-phase req/ack handshake; the processor's data-cache stage.
- Feeds the register file stage of the asynchronous processor.
- Each handshake transaction atomically commits up to three writes and captures up to three reads.
- The req input is treated as asynchronous and is synchronized internally.

Parameters:
- N, 32, data word width.
- ADDRESS_SIZE, 12, address width; depth = 2^ADDRESS_SIZE words.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- write_data_1..3  input  N  write data, ports 1-3.
- wac_1..3  input  ADDRESS_SIZE  write addresses, ports 1-3.
- rac_1..3  input  ADDRESS_SIZE  read addresses, ports 1-3.
- write_enable_1..3  input  1  per-port write enable.
- read_enable_1..3  input  1  per-port read enable.
- out_data_1..3  output  N  registered read data, ports 1-3.
- req  input  1  four-phase request, asynchronous to clk.
- ack  output  1  four-phase acknowledge.
- trig  output  1  one-cycle pulse marking transaction completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ack=0, trig=0, out_data_1..3=0, synchronizer flops=0.
  - Memory array is not reset; contents are undefined until written.
- req synchronizer: two flops; req_s = req delayed by two rising edges.
- Commit edge: any rising edge where req_s=1 and ack=0. At that edge:
  - Reads: for each port i with read_enable_i=1, out_data_i <= mem[rac_i]. This is the pre-write (old) value, i.e. read-before-write within a transaction. Ports with read_enable_i=0 hold their previous out_data_i.
  - Writes: for each port i with write_enable_i=1, mem[wac_i] <= write_data_i.
  - Same-address write conflict: port 3 beats port 2 beats port 1.
  - ack <= 1, trig <= 1.
- trig is high for exactly one cycle: cleared on the edge after the commit edge.
- Completion: while ack=1 and req_s=1, nothing happens; a held req never causes a second commit.
- Release: on the edge where req_s=0 and ack=1, ack <= 0. The next commit requires req_s=1 again.
- Latency:
  - req rise to ack rise = 3 rising edges (2 synchronizer + 1 commit).
  - req fall to ack fall = 3 rising edges.
- Requester must hold data, addresses and enables stable from req rise until it observes ack=1.
- Enable changes outside a commit edge have no effect.
- Transactions are atomic: memory changes only on commit edges. A reset asserted before the commit edge leaves memory untouched and aborts the handshake (ack=0).
- Addresses span the full 2^ADDRESS_SIZE range: 0 and 4095 are both legal, with no wrap or aliasing.
- A transaction with all enables low still completes the handshake (ack/trig) and changes no data.

Test Plan:
- Reset: assert rst_n=0 mid-handshake -> ack=0, trig=0, out_data_1..3=0 immediately, with no clock required.
- Single write, then read:
  - Transaction 1: write port 1 addr 0x005 data 0xDEADBEEF.
  - Transaction 2: read port 2 addr 0x005.
  - Expected: out_data_2=0xDEADBEEF after transaction 2's commit edge; ack rises exactly 3 edges after each req rise; trig is high for one cycle.
- Three parallel writes:
  - Writes to 0x000, 0x7FF, 0xFFF with 0x11111111, 0x22222222, 0x33333333.
  - Read the three addresses on ports 1-3 in the next transaction.
  - Expected: outputs equal 0x11111111, 0x22222222, 0x33333333.
- Conflict and read-before-write:
  - Preload addr 0x010=0xAAAAAAAA.
  - Then ports 1 and 3 both write 0x010 (0x1 and 0x3) while port 1 reads 0x010 in the same transaction.
  - Expected: out_data_1=0xAAAAAAAA; a later read of 0x010 gives 0x00000003.
- Held req: keep req high for 10 cycles after ack -> exactly one commit and one trig pulse. Drop req -> ack=0 three edges later.
- Disabled read: read_enable_2=0 during a transaction -> out_data_2 keeps its prior value.
